// File: rtl/rv32_enc_pkg.sv
// Shared types, opcodes and immediate range limits for the RV32 instruction encoder.
// The range helper treats the 32-bit immediate as two's complement.
package rv32_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_LI   = 3'd6,
    FMT_RSVD = 3'd7
  } fmt_e;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_e;

  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -(1 << 20);
  localparam int IMM_J_MAX = (1 << 20) - 2;

  function automatic logic in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/rv32_instr_pack.sv
// Combinational field packing and immediate checking for one encoder request.
// For LI it also produces the second (ADDI) word and flags whether it is needed.
module rv32_instr_pack
  import rv32_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic [31:0] word2,
  output logic        two_beat,
  output logic        err
);

  logic        fits12;
  logic [19:0] li_hi;

  assign fits12 = in_range(imm, IMM12_MIN, IMM12_MAX);
  // Upper part rounded so that the sign-extended ADDI low part lands on imm.
  assign li_hi  = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    word     = '0;
    word2    = '0;
    two_beat = 1'b0;
    err      = 1'b0;
    case (fmt_e'(fmt))
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        err  = !fits12;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !fits12;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = !in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        err  = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = !in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
      end
      FMT_LI: begin
        if (fits12) begin
          word = {imm[11:0], 5'd0, 3'b000, rd, OPC_OPIMM};
        end else begin
          word     = {li_hi, rd, OPC_LUI};
          word2    = {imm[11:0], rd, 3'b000, rd, OPC_OPIMM};
          two_beat = (imm[11:0] != 12'd0);
        end
      end
      default: begin
        word = {25'd0, opcode};
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv32_instr_enc.sv
// RV32 instruction encoder: valid/ready request in, registered instruction beats out.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds data stable while valid && !ready.
module rv32_instr_enc
  import rv32_enc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit NOP_ON_ERR = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_fmt,
  input  logic [6:0]      req_opcode,
  input  logic [4:0]      req_rd,
  input  logic [4:0]      req_rs1,
  input  logic [4:0]      req_rs2,
  input  logic [2:0]      req_funct3,
  input  logic [6:0]      req_funct7,
  input  logic [XLEN-1:0] req_imm,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic            instr_last,
  output logic            instr_err
);

  state_e          state, state_nxt;
  logic [XLEN-1:0] pk_word, pk_word2, pend_q;
  logic            pk_two, pk_err;
  logic            accept, out_fire, load_second;

  rv32_instr_pack u_pack (
    .fmt      (req_fmt),
    .opcode   (req_opcode),
    .rd       (req_rd),
    .rs1      (req_rs1),
    .rs2      (req_rs2),
    .funct3   (req_funct3),
    .funct7   (req_funct7),
    .imm      (req_imm),
    .word     (pk_word),
    .word2    (pk_word2),
    .two_beat (pk_two),
    .err      (pk_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept && pk_two) state_nxt = S_SECOND;
      S_SECOND: if (out_fire)         state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = rst_n && (state == S_IDLE) && (!instr_valid || instr_ready);
    accept      = req_valid && req_ready;
    out_fire    = instr_valid && instr_ready;
    load_second = (state == S_SECOND) && out_fire;
  end

  // A new acceptance overwrites the output in the same cycle its previous beat drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_last  <= 1'b0;
      instr_err   <= 1'b0;
      pend_q      <= '0;
    end else if (accept) begin
      instr_valid <= 1'b1;
      instr       <= (pk_err && NOP_ON_ERR) ? NOP_INSTR : pk_word;
      instr_last  <= !pk_two;
      instr_err   <= pk_err;
      pend_q      <= pk_word2;
    end else if (load_second) begin
      instr       <= pend_q;
      instr_last  <= 1'b1;
      instr_err   <= 1'b0;
    end else if (out_fire) begin
      instr_valid <= 1'b0;
    end
  end

endmodule
